laser_cover_search: RTL and testbench
=====================================

Name: laser_cover_search

Overview:
- Parametrised two-circle coverage search engine, next generation of the contest laser-placement block.
- Loads NPTS target points through a valid/ready interface, then raster-scans every grid candidate to place circle 1 and circle 2 so their union covers the most points.
- Circles are refined alternately, pass by pass, until the count stops improving or MAX_PASS is reached.
- Adds per-cycle lane parallelism, a configurable radius and grid size, an explicit covered-count output, and held results.

Parameters:
COORD_W, 4, coordinate width; grid is 2^COORD_W x 2^COORD_W
NPTS, 40, points per job; must be a multiple of LANES
LANES, 2, points evaluated per cycle (1, 2, 4 or 5 must divide NPTS)
RADIUS_SQ, 16, inclusive squared radius
MAX_PASS, 6, maximum refinement passes (>=1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  X/Y valid
X  in  COORD_W  point x
Y  in  COORD_W  point y
IN_READY  out  1  high only in LOAD
C1X, C1Y  out  COORD_W each  circle-1 centre result
C2X, C2Y  out  COORD_W each  circle-2 centre result
CNT  out  clog2(NPTS+1)  points covered by union of result circles
DONE  out  1  one-cycle pulse; results valid from this cycle

Behaviour:
- Reset (async assert, sync release):
  - state LOAD; all outputs 0; IN_READY goes 1 in the first cycle after release.
  - Internal point memory contents don't care.
- LOAD:
  - A point is written at index load_cnt when IN_VALID && IN_READY; otherwise nothing happens.
  - After the NPTS-th accept, go to SCAN with pass=0, candidate=(0,0); IN_READY drops the following cycle.
  - Inputs are ignored outside LOAD.
- Inside test: |dx| and |dy| computed at COORD_W bits without wrap (compare then subtract).
  - Sum of squares kept at 2*COORD_W+1 bits; inside iff sum <= RADIUS_SQ.
- Pass p optimises circle A = (p even ? 1 : 2); circle B is the other one, held fixed at its working value.
  - In pass 0 circle B is disabled and covers nothing.
  - A point counts once if inside A-candidate or inside enabled B.
- SCAN:
  - Candidates in raster order: x inner 0..2^W-1, y outer.
  - Each candidate takes NPTS/LANES cycles; lane k in slice s tests point s*LANES+k.
  - The accumulator adds 0..LANES per cycle and clears at the start of each candidate.
  - At the candidate's last slice: if total >= pass_best, the working A centre becomes the candidate and pass_best becomes total. Ties go to the latest raster candidate.
  - pass_best is cleared at pass start.
- PASS_END (1 cycle), entered after candidate (2^W-1, 2^W-1):
  - Go to DONE if p+1 == MAX_PASS, or if p >= 1 and pass_best == prev_best.
  - Otherwise prev_best <= pass_best, p <= p+1, back to SCAN.
- DONE (1 cycle):
  - DONE=1; C1X/C1Y/C2X/C2Y/CNT load the working centres and pass_best.
  - The circle never optimised (MAX_PASS=1) outputs 0.
  - Next state LOAD. Results hold until the next DONE or reset, including throughout the next job's LOAD and SCAN.
- Latency, last accept to DONE: passes * (4^COORD_W * NPTS/LANES + 1) + 1 cycles.
  - Defaults: 5121 cycles per pass, plus 1.
- Reset mid-operation aborts the job immediately; no DONE is produced; outputs return to 0.
- pass_best is monotonic across passes (B's cover is retained), so prev_best <= pass_best always holds.

Test Plan:
- Defaults, all 40 points at (5,5):
  - Pass 0: C1=(5,9). Pass 1: all candidates give 40, so C2=(15,15); stops.
  - DONE with C1=(5,9), C2=(15,15), CNT=40, exactly 2*5121+1 cycles after the last accept.
- Defaults, 20 points at (2,2) and 20 at (13,13):
  - Pass 0: C1=(15,15), count 20. Pass 1: C2=(2,6), count 40. Pass 2: C1=(15,15), count 40; stops.
  - Outputs C1=(15,15), C2=(2,6), CNT=40.
- IN_VALID toggled randomly during load, plus extra points driven after the 40th accept:
  - Extras ignored; IN_READY=0 from SCAN through DONE; same results as the un-gapped run.
- Assert RST_N low mid-SCAN of pass 1:
  - Outputs 0 asynchronously; no DONE.
  - After release, IN_READY=1; a fresh 40-point load completes normally.
- MAX_PASS=1, scenario-2 data:
  - DONE after 1 pass; C1=(15,15), C2=(0,0), CNT=20.
- LANES=1, COORD_W=4, scenario-2 data:
  - Identical outputs; per-pass SCAN length 10240 cycles.
  - Back-to-back second job: results held until its DONE.

Source files
------------

// File: rtl/laser_cover_search_if.sv
// Point-load handshake and result bus for laser_cover_search.
//   master (job source): drives IN_VALID/X/Y, observes IN_READY and the results.
//   slave  (search engine): accepts points, returns C1X/C1Y/C2X/C2Y/CNT and the DONE pulse.
interface laser_cover_search_if #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned NPTS    = 40
);
  localparam int unsigned CNT_W = $clog2(NPTS + 1);

  logic               IN_VALID;
  logic [COORD_W-1:0] X;
  logic [COORD_W-1:0] Y;
  logic               IN_READY;
  logic [COORD_W-1:0] C1X;
  logic [COORD_W-1:0] C1Y;
  logic [COORD_W-1:0] C2X;
  logic [COORD_W-1:0] C2Y;
  logic [CNT_W-1:0]   CNT;
  logic               DONE;

  modport master (
    output IN_VALID, X, Y,
    input  IN_READY, C1X, C1Y, C2X, C2Y, CNT, DONE
  );

  modport slave (
    input  IN_VALID, X, Y,
    output IN_READY, C1X, C1Y, C2X, C2Y, CNT, DONE
  );
endinterface

// File: rtl/laser_cover_search.sv
// Two-circle coverage search: loads NPTS points, then raster-scans every grid
// candidate for one circle at a time (the other held fixed) and refines the
// pair pass by pass until the covered count stops improving or MAX_PASS runs out.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : point load (IN_VALID/X/Y/IN_READY) and held results with DONE pulse
module laser_cover_search #(
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned NPTS      = 40,
  parameter int unsigned LANES     = 2,
  parameter int unsigned RADIUS_SQ = 16,
  parameter int unsigned MAX_PASS  = 6
) (
  input logic                CLK,
  input logic                RST_N,
  laser_cover_search_if.slave bus
);
  localparam int unsigned NSLICE  = NPTS / LANES;
  localparam int unsigned SLICE_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned IDX_W   = $clog2(NPTS);
  localparam int unsigned CNT_W   = $clog2(NPTS + 1);
  localparam int unsigned PASS_W  = $clog2(MAX_PASS + 1);
  localparam int unsigned SQ_W    = 2 * COORD_W + 1;

  typedef enum logic [1:0] {S_LOAD, S_SCAN, S_PASS_END, S_DONE} state_t;

  state_t             state, next_state;
  logic [COORD_W-1:0] pts_x [NPTS];
  logic [COORD_W-1:0] pts_y [NPTS];
  logic [IDX_W-1:0]   load_cnt;
  logic [SLICE_W-1:0] slice;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [COORD_W-1:0] w1x, w1y, w2x, w2y;
  logic [CNT_W-1:0]   acc, pass_best, prev_best;
  logic [PASS_W-1:0]  pass_q;
  logic               in_ready_q, done_q;
  logic [COORD_W-1:0] c1x_q, c1y_q, c2x_q, c2y_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept_c, last_pt_c, last_slice_c, last_cand_c;
  logic               a_is_c2_c, b_en_c, better_c, finish_c;
  logic [COORD_W-1:0] bx_c, by_c;
  logic [CNT_W-1:0]   lane_sum_c, total_c;

  // Distances are formed as compare-then-subtract so they never wrap.
  function automatic logic in_circle(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                     input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy);
    logic [COORD_W-1:0] dx, dy;
    logic [SQ_W-1:0]    sum;
    dx  = (px >= cx) ? px - cx : cx - px;
    dy  = (py >= cy) ? py - cy : cy - py;
    sum = SQ_W'(dx) * SQ_W'(dx) + SQ_W'(dy) * SQ_W'(dy);
    return sum <= SQ_W'(RADIUS_SQ);
  endfunction

  assign accept_c     = bus.IN_VALID && in_ready_q;
  assign last_pt_c    = (load_cnt == IDX_W'(NPTS - 1));
  assign last_slice_c = (slice == SLICE_W'(NSLICE - 1));
  assign last_cand_c  = (&cand_x) && (&cand_y);
  // Odd passes move circle 2; the other circle only counts after pass 0.
  assign a_is_c2_c    = pass_q[0];
  assign b_en_c       = (pass_q != '0);
  assign bx_c         = a_is_c2_c ? w1x : w2x;
  assign by_c         = a_is_c2_c ? w1y : w2y;
  assign total_c      = acc + lane_sum_c;
  assign better_c     = (total_c >= pass_best);
  assign finish_c     = (pass_q == PASS_W'(MAX_PASS - 1)) ||
                        ((pass_q != '0) && (pass_best == prev_best));

  // Union coverage of the current slice: each lane tests one point.
  always_comb begin
    lane_sum_c = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_sum_c = lane_sum_c + CNT_W'(
        in_circle(pts_x[IDX_W'(32'(slice) * LANES + k)], pts_y[IDX_W'(32'(slice) * LANES + k)],
                  cand_x, cand_y) ||
        (b_en_c && in_circle(pts_x[IDX_W'(32'(slice) * LANES + k)],
                             pts_y[IDX_W'(32'(slice) * LANES + k)], bx_c, by_c)));
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_LOAD;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_LOAD:     if (accept_c && last_pt_c) next_state = S_SCAN;
      S_SCAN:     if (last_slice_c && last_cand_c) next_state = S_PASS_END;
      S_PASS_END: next_state = finish_c ? S_DONE : S_SCAN;
      S_DONE:     next_state = S_LOAD;
      default:    next_state = S_LOAD;
    endcase
  end

  // Point memory; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (accept_c) begin
      pts_x[load_cnt] <= bus.X;
      pts_y[load_cnt] <= bus.Y;
    end
  end

  // Search datapath and held results.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      load_cnt   <= '0;
      slice      <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      acc        <= '0;
      pass_best  <= '0;
      prev_best  <= '0;
      pass_q     <= '0;
      w1x        <= '0;
      w1y        <= '0;
      w2x        <= '0;
      w2y        <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      c1x_q      <= '0;
      c1y_q      <= '0;
      c2x_q      <= '0;
      c2y_q      <= '0;
      cnt_q      <= '0;
    end else begin
      in_ready_q <= (next_state == S_LOAD);
      done_q     <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept_c) begin
            load_cnt <= last_pt_c ? '0 : load_cnt + IDX_W'(1);
            if (last_pt_c) begin
              slice     <= '0;
              cand_x    <= '0;
              cand_y    <= '0;
              acc       <= '0;
              pass_best <= '0;
              prev_best <= '0;
              pass_q    <= '0;
              w1x       <= '0;
              w1y       <= '0;
              w2x       <= '0;
              w2y       <= '0;
            end
          end
        end
        S_SCAN: begin
          if (last_slice_c) begin
            acc   <= '0;
            slice <= '0;
            // >= lets the latest raster candidate win ties.
            if (better_c) begin
              pass_best <= total_c;
              if (a_is_c2_c) begin
                w2x <= cand_x;
                w2y <= cand_y;
              end else begin
                w1x <= cand_x;
                w1y <= cand_y;
              end
            end
            cand_x <= cand_x + COORD_W'(1);
            if (&cand_x) cand_y <= cand_y + COORD_W'(1);
          end else begin
            acc   <= total_c;
            slice <= slice + SLICE_W'(1);
          end
        end
        S_PASS_END: begin
          if (finish_c) begin
            done_q <= 1'b1;
            c1x_q  <= w1x;
            c1y_q  <= w1y;
            c2x_q  <= w2x;
            c2y_q  <= w2y;
            cnt_q  <= pass_best;
          end else begin
            prev_best <= pass_best;
            pass_best <= '0;
            pass_q    <= pass_q + PASS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.IN_READY = in_ready_q;
  assign bus.DONE     = done_q;
  assign bus.C1X      = c1x_q;
  assign bus.C1Y      = c1y_q;
  assign bus.C2X      = c2x_q;
  assign bus.C2Y      = c2y_q;
  assign bus.CNT      = cnt_q;
endmodule

// File: tb/tb_laser_cover_search.sv
// Self-checking bench for laser_cover_search: directed scenarios plus random
// point sets checked against an algorithmic model of the coverage search.
module tb_laser_cover_search;
  localparam int unsigned W = 4;
  localparam int unsigned N = 40;
  localparam int PASS_A = 5121;   // 256 candidates * 20 slices + 1
  localparam int PASS_C = 10241;  // 256 candidates * 40 slices + 1

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  laser_cover_search_if #(.COORD_W(W), .NPTS(N)) if_a ();
  laser_cover_search_if #(.COORD_W(W), .NPTS(N)) if_b ();
  laser_cover_search_if #(.COORD_W(W), .NPTS(N)) if_c ();

  laser_cover_search #(.COORD_W(W), .NPTS(N), .LANES(2), .RADIUS_SQ(16), .MAX_PASS(6))
    dut_a (.CLK(CLK), .RST_N(RST_N), .bus(if_a));
  laser_cover_search #(.COORD_W(W), .NPTS(N), .LANES(2), .RADIUS_SQ(16), .MAX_PASS(1))
    dut_b (.CLK(CLK), .RST_N(RST_N), .bus(if_b));
  laser_cover_search #(.COORD_W(W), .NPTS(N), .LANES(1), .RADIUS_SQ(16), .MAX_PASS(6))
    dut_c (.CLK(CLK), .RST_N(RST_N), .bus(if_c));

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int acc_a = 0, acc_b = 0, acc_c = 0;
  int acyc_a = 0, acyc_b = 0, acyc_c = 0;
  int done_c = 0, dcyc_c = 0;

  always @(negedge CLK) begin
    if (if_a.IN_VALID && if_a.IN_READY) begin acc_a++; acyc_a = cyc; end
    if (if_b.IN_VALID && if_b.IN_READY) begin acc_b++; acyc_b = cyc; end
    if (if_c.IN_VALID && if_c.IN_READY) begin acc_c++; acyc_c = cyc; end
    if (if_c.DONE) begin done_c++; dcyc_c = cyc; end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int px [N];
  int py [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_o(input int i, input int f);
    logic [31:0] r [5];
    case (i)
      0: begin r[0] = 32'(if_a.C1X); r[1] = 32'(if_a.C1Y); r[2] = 32'(if_a.C2X);
               r[3] = 32'(if_a.C2Y); r[4] = 32'(if_a.CNT); end
      1: begin r[0] = 32'(if_b.C1X); r[1] = 32'(if_b.C1Y); r[2] = 32'(if_b.C2X);
               r[3] = 32'(if_b.C2Y); r[4] = 32'(if_b.CNT); end
      default: begin r[0] = 32'(if_c.C1X); r[1] = 32'(if_c.C1Y); r[2] = 32'(if_c.C2X);
               r[3] = 32'(if_c.C2Y); r[4] = 32'(if_c.CNT); end
    endcase
    return r[f];
  endfunction

  function automatic logic [31:0] get_ready(input int i);
    case (i)
      0: return 32'(if_a.IN_READY);
      1: return 32'(if_b.IN_READY);
      default: return 32'(if_c.IN_READY);
    endcase
  endfunction

  function automatic logic [31:0] get_done(input int i);
    case (i)
      0: return 32'(if_a.DONE);
      1: return 32'(if_b.DONE);
      default: return 32'(if_c.DONE);
    endcase
  endfunction

  function automatic int get_acyc(input int i);
    case (i)
      0: return acyc_a;
      1: return acyc_b;
      default: return acyc_c;
    endcase
  endfunction

  task automatic check_res(input int i, input string tag, input int e1x, input int e1y,
                           input int e2x, input int e2y, input int ecnt);
    check({tag, "_c1x"}, get_o(i, 0), 32'(e1x));
    check({tag, "_c1y"}, get_o(i, 1), 32'(e1y));
    check({tag, "_c2x"}, get_o(i, 2), 32'(e2x));
    check({tag, "_c2y"}, get_o(i, 3), 32'(e2y));
    check({tag, "_cnt"}, get_o(i, 4), 32'(ecnt));
  endtask

  // Reference: exhaustive alternating refinement computed directly from the rules.
  function automatic bit in_circle(input int ax, input int ay, input int bx, input int by);
    return (ax - bx) * (ax - bx) + (ay - by) * (ay - by) <= 16;
  endfunction

  function automatic void model(input int maxp, output int o1x, output int o1y, output int o2x,
                                output int o2y, output int ocnt, output int opass);
    int wx [2];
    int wy [2];
    int prev, best, c, a;
    wx[0] = 0; wy[0] = 0; wx[1] = 0; wy[1] = 0;
    prev = 0; best = 0; opass = 0;
    for (int p = 0; p < maxp; p++) begin
      a = p % 2;
      best = 0;
      for (int y = 0; y < 16; y++) begin
        for (int x = 0; x < 16; x++) begin
          c = 0;
          for (int i = 0; i < int'(N); i++)
            if (in_circle(px[i], py[i], x, y) ||
                (p > 0 && in_circle(px[i], py[i], wx[1-a], wy[1-a]))) c++;
          if (c >= best) begin best = c; wx[a] = x; wy[a] = y; end
        end
      end
      opass = p + 1;
      if (p >= 1 && best == prev) break;
      prev = best;
    end
    o1x = wx[0]; o1y = wy[0]; o2x = wx[1]; o2y = wy[1]; ocnt = best;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
    if (sel[0]) begin if_a.IN_VALID = v; if_a.X = x; if_a.Y = y; end
    if (sel[1]) begin if_b.IN_VALID = v; if_b.X = x; if_b.Y = y; end
    if (sel[2]) begin if_c.IN_VALID = v; if_c.X = x; if_c.Y = y; end
  endtask

  function automatic logic ready_all(input int sel);
    logic r;
    r = 1'b1;
    if (sel[0] && !if_a.IN_READY) r = 1'b0;
    if (sel[1] && !if_b.IN_READY) r = 1'b0;
    if (sel[2] && !if_c.IN_READY) r = 1'b0;
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge of the last accept.
  task automatic load_job(input int sel, input bit gappy);
    int gap, tries;
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      if (gappy) begin
        gap = int'($urandom_range(0, 2));
        repeat (gap) begin
          drive(sel, 1'b0, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
          @(posedge CLK); #1;
        end
      end
      drive(sel, 1'b1, W'(px[i]), W'(py[i]));
      tries = 0;
      @(negedge CLK);
      while (!ready_all(sel) && tries < 8) begin @(negedge CLK); tries++; end
      if (tries >= 8) ok = 1'b0;
      @(posedge CLK); #1;
    end
    drive(sel, 1'b0, '0, '0);
    check("load_ready", 32'(ok), 32'd1);
  endtask

  // Returns at the falling edge one cycle after the DONE pulse.
  task automatic wait_done(input int i, input int budget, input int exp_lat, input string tag);
    int t;
    t = 0;
    @(negedge CLK);
    while (get_done(i) != 32'd1 && t < budget) begin @(negedge CLK); t++; end
    check({tag, "_done"}, get_done(i), 32'd1);
    check({tag, "_lat"}, 32'(cyc - get_acyc(i)), 32'(exp_lat));
    check({tag, "_rdy_in_done"}, get_ready(i), 32'd0);
    @(negedge CLK);
    check({tag, "_pulse"}, get_done(i), 32'd0);
    check({tag, "_rdy_after"}, get_ready(i), 32'd1);
  endtask

  task automatic set_scen2();
    for (int i = 0; i < int'(N); i++) begin
      px[i] = (i < 20) ? 2 : 13;
      py[i] = (i < 20) ? 2 : 13;
    end
  endtask

  int m1x, m1y, m2x, m2y, mcnt, mpass;
  int b1x, b1y, b2x, b2y, bcnt, bpass;
  int acc_before, t;

  initial begin
    drive(7, 1'b0, '0, '0);
    repeat (3) @(negedge CLK);
    check_res(0, "rst_a", 0, 0, 0, 0, 0);
    check_res(2, "rst_c", 0, 0, 0, 0, 0);
    check("rst_rdy_a", get_ready(0), 32'd0);
    check("rst_done_a", get_done(0), 32'd0);
    #2 RST_N = 1'b1;
    @(posedge CLK); #1;
    check("rel_rdy_a", get_ready(0), 32'd1);
    check("rel_rdy_b", get_ready(1), 32'd1);
    check("rel_rdy_c", get_ready(2), 32'd1);

    // Scenario 1: all points at (5,5).
    for (int i = 0; i < int'(N); i++) begin px[i] = 5; py[i] = 5; end
    load_job(1, 1'b0);
    check("s1_rdy_drop", get_ready(0), 32'd0);
    wait_done(0, 3 * PASS_A, 2 * PASS_A + 1, "s1");
    check_res(0, "s1", 5, 9, 15, 15, 40);

    // Scenario 2 on all three configurations at once.
    @(posedge CLK); #1;
    set_scen2();
    load_job(7, 1'b0);
    wait_done(1, PASS_A + 20, PASS_A + 1, "s2b");
    check_res(1, "s2b", 15, 15, 0, 0, 20);
    wait_done(0, 3 * PASS_A, 3 * PASS_A + 1, "s2a");
    check_res(0, "s2a", 15, 15, 2, 6, 40);
    check_res(1, "s2b_hold", 15, 15, 0, 0, 20);

    // Back-to-back gapped load on dut_a with extra points after the last accept.
    @(posedge CLK); #1;
    acc_before = acc_a;
    load_job(1, 1'b1);
    check("gap_rdy_drop", get_ready(0), 32'd0);
    repeat (5) begin
      drive(1, 1'b1, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      @(posedge CLK); #1;
    end
    drive(1, 1'b0, '0, '0);
    check("gap_accepts", 32'(acc_a - acc_before), 32'd40);
    repeat (3000) @(posedge CLK);
    #1;
    check("gap_rdy_scan", get_ready(0), 32'd0);
    check_res(0, "gap_hold", 15, 15, 2, 6, 40);
    wait_done(0, 3 * PASS_A, 3 * PASS_A + 1, "gap");
    check_res(0, "gap", 15, 15, 2, 6, 40);

    // Single-lane configuration finishing scenario 2.
    t = 0;
    while (done_c == 0 && t < 4 * PASS_C) begin @(negedge CLK); t++; end
    check("s2c_done_cnt", 32'(done_c), 32'd1);
    check("s2c_lat", 32'(dcyc_c - acyc_c), 32'(3 * PASS_C + 1));
    check_res(2, "s2c", 15, 15, 2, 6, 40);

    // Random job aborted by reset during pass 1, then reloaded.
    @(posedge CLK); #1;
    for (int i = 0; i < int'(N); i++) begin
      px[i] = int'($urandom_range(0, 15));
      py[i] = int'($urandom_range(0, 15));
    end
    model(6, m1x, m1y, m2x, m2y, mcnt, mpass);
    model(1, b1x, b1y, b2x, b2y, bcnt, bpass);
    load_job(1, 1'b0);
    repeat (PASS_A + 300) @(posedge CLK);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check_res(0, "rst_async_a", 0, 0, 0, 0, 0);
    check_res(2, "rst_async_c", 0, 0, 0, 0, 0);
    check("rst_async_rdy", get_ready(0), 32'd0);
    repeat (2) @(negedge CLK);
    check("rst_hold_done", get_done(0), 32'd0);
    check("rst_hold_cnt", get_o(0, 4), 32'd0);
    #2 RST_N = 1'b1;
    @(posedge CLK); #1;
    check("rst_rel_rdy_a", get_ready(0), 32'd1);
    check("rst_rel_rdy_b", get_ready(1), 32'd1);
    load_job(3, 1'b0);
    wait_done(1, PASS_A + 20, PASS_A + 1, "rndb");
    check_res(1, "rndb", b1x, b1y, b2x, b2y, bcnt);
    wait_done(0, mpass * PASS_A + 20, mpass * PASS_A + 1, "rnda");
    check_res(0, "rnda", m1x, m1y, m2x, m2y, mcnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
